// File: rtl/bus_mux_reg_pkg.sv
// Shared definitions for the registered bus multiplexer.
//   - Source index constants in bus order (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR)
//   - Lock state encoding
//   - Default bus width and source count
package bus_mux_reg_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NSRC  = 22;

    localparam int SRC_R0  = 0;
    localparam int SRC_R1  = 1;
    localparam int SRC_R2  = 2;
    localparam int SRC_R3  = 3;
    localparam int SRC_R4  = 4;
    localparam int SRC_R5  = 5;
    localparam int SRC_R6  = 6;
    localparam int SRC_R7  = 7;
    localparam int SRC_R8  = 8;
    localparam int SRC_R9  = 9;
    localparam int SRC_R10 = 10;
    localparam int SRC_R11 = 11;
    localparam int SRC_R12 = 12;
    localparam int SRC_R13 = 13;
    localparam int SRC_R14 = 14;
    localparam int SRC_R15 = 15;
    localparam int SRC_HI  = 16;
    localparam int SRC_LO  = 17;
    localparam int SRC_ZHI = 18;
    localparam int SRC_ZLO = 19;
    localparam int SRC_PC  = 20;
    localparam int SRC_MDR = 21;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/bus_mux_reg_prio_enc.sv
// Combinational priority encoder over the drive enables.
// Ports:
//   req   in  NSRC   one-hot / multi-hot request vector
//   idx   out IDX_W  index of the winning request (0 when none)
//   any   out 1      at least one request asserted
//   multi out 1      more than one request asserted
// HI_PRIO=1 -> highest asserted index wins; HI_PRIO=0 -> lowest wins.
module prio_enc
    import bus_mux_reg_pkg::*;
#(
    parameter int NSRC    = DEF_NSRC,
    parameter int HI_PRIO = 1,
    parameter int IDX_W   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx = '0;
        if (HI_PRIO != 0) begin
            // Ascending scan: the last hit, i.e. the highest index, sticks.
            for (int i = 0; i < NSRC; i++) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end
    end

    assign any   = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - NSRC'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus multiplexer with priority select, bus lock and conflict
// monitoring.
// Ports:
//   clock        in  1           rising-edge clock
//   clear_n      in  1           asynchronous active-low reset
//   src_out      in  NSRC        drive enables, bit i = source i drives
//   src_data     in  NSRC*WIDTH  flattened source data, [i*WIDTH +: WIDTH]
//   lock_req     in  1           keep the bus reserved for the current owner
//   err_clr      in  1           clear conflict_err and conflict_cnt
//   bus_out      out WIDTH       registered bus value (holds when undriven)
//   bus_valid    out 1           bus_out was loaded from a source last edge
//   owner_idx    out clog2(NSRC) index of the source captured into bus_out
//   locked       out 1           lock active
//   conflict     out 1           one-cycle pulse after an offending sample
//   conflict_err out 1           sticky conflict flag
//   conflict_cnt out CNT_W       saturating conflict count
module bus_mux_reg
    import bus_mux_reg_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NSRC    = DEF_NSRC,
    parameter int HI_PRIO = 1,
    parameter int CNT_W   = 8
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic [NSRC-1:0]           src_out,
    input  logic [NSRC*WIDTH-1:0]     src_data,
    input  logic                      lock_req,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          bus_out,
    output logic                      bus_valid,
    output logic [$clog2(NSRC)-1:0]   owner_idx,
    output logic                      locked,
    output logic                      conflict,
    output logic                      conflict_err,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int IDX_W = $clog2(NSRC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lock_state_t      state_reg, state_next;
    logic [WIDTH-1:0] bus_reg;
    logic [IDX_W-1:0] owner_reg;   // doubles as the lock owner while LOCKED
    logic             valid_reg;
    logic             conflict_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;
    logic [NSRC-1:0]  owner_hit;
    logic             owner_en;
    logic             others_en;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             conflict_next;

    prio_enc #(
        .NSRC    (NSRC),
        .HI_PRIO (HI_PRIO),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req   (src_out),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // One-hot decode of the current owner, used to split enables into
    // "owner" and "everyone else" while the bus is locked.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_owner_hit
            assign owner_hit[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    assign owner_en  = |(src_out & owner_hit);
    assign others_en = |(src_out & ~owner_hit);

    // Lock FSM next state and winner selection.
    always_comb begin
        state_next    = state_reg;
        win_valid     = enc_any;
        win_idx       = enc_idx;
        conflict_next = enc_multi;
        case (state_reg)
            ST_UNLOCKED: begin
                if (lock_req && enc_any) state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                win_valid     = owner_en;
                win_idx       = owner_reg;
                conflict_next = others_en;
                if (!lock_req) state_next = ST_UNLOCKED;
            end
            default: state_next = ST_UNLOCKED;
        endcase
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (win_idx == IDX_W'(i)) win_data = src_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg    <= ST_UNLOCKED;
            bus_reg      <= '0;
            owner_reg    <= '0;
            valid_reg    <= 1'b0;
            conflict_reg <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= win_valid;
            conflict_reg <= conflict_next;
            // Undriven cycles keep the previous bus value and owner.
            // Taking the lock also latches the owner here, since the lock
            // is only granted when a winner exists.
            if (win_valid) begin
                bus_reg   <= win_data;
                owner_reg <= win_idx;
            end
            // Clear wins over a same-cycle conflict; that conflict is dropped.
            if (err_clr) begin
                err_reg <= 1'b0;
                cnt_reg <= '0;
            end else if (conflict_next) begin
                err_reg <= 1'b1;
                if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus_out      = bus_reg;
    assign bus_valid    = valid_reg;
    assign owner_idx    = owner_reg;
    assign locked       = (state_reg == ST_LOCKED);
    assign conflict     = conflict_reg;
    assign conflict_err = err_reg;
    assign conflict_cnt = cnt_reg;

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NSRC WIDTH-bit sources from one-hot drive enables and registers the result onto the bus.
- Adds programmable priority, multi-driver conflict detection with a saturating counter and sticky error, hold-last-value when undriven, and a lock mode that reserves the bus for one owner across several cycles.
- Sits between the register file/special registers (HI, LO, Z, PC, MDR) and all bus consumers.

Parameters:
- WIDTH, 32, bus data width in bits.
- NSRC, 22, number of sources; index order is R0..R15, HI, LO, Zhigh, Zlow, PC, MDR.
- HI_PRIO, 1, 1 = highest asserted index wins (legacy order, MDR over PC over R0); 0 = lowest index wins.
- CNT_W, 8, conflict counter width.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- src_out  in  NSRC  one-hot drive enables; bit i = source i drives.
- src_data  in  NSRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- lock_req  in  1  hold the bus for the current owner while high.
- err_clr  in  1  clears conflict_err and conflict_cnt.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out was driven by a source in the previous cycle.
- owner_idx  out  $clog2(NSRC)  index of the source captured into bus_out.
- locked  out  1  lock is active.
- conflict  out  1  one-cycle pulse: more than one enable was seen, or a non-owner enable was seen while locked.
- conflict_err  out  1  sticky error flag.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (async, clear_n=0): bus_out=0, bus_valid=0, owner_idx=0, locked=0, conflict=0, conflict_err=0, conflict_cnt=0. A reset mid-lock drops the lock immediately.
- Latency: src_out/src_data sampled at edge k appear on bus_out, owner_idx and bus_valid after edge k.
- Winner, unlocked: the priority encoder chooses among asserted bits per HI_PRIO.
- Winner, locked: the winner is the latched owner if its enable is high; all other enables are ignored.
- No winner: bus_out and owner_idx hold their previous values and bus_valid=0. Legacy latch behaviour becomes an explicit register hold.
- The lock uses two states:
  - UNLOCKED -> LOCKED on an edge where lock_req=1 and a winner exists. The owner latches to that winner and locked=1 from the next cycle.
  - LOCKED -> UNLOCKED on the first edge with lock_req=0.
  - lock_req=1 with no enable keeps UNLOCKED.
  - In LOCKED, an owner enable low gives no winner, so the bus holds.
- conflict is registered and pulses for exactly the cycle after the offending sample. It pulses when:
  - popcount(src_out) > 1 while UNLOCKED; the winner is still driven.
  - any non-owner bit is set while LOCKED.
- conflict_err sets on any conflict.
- conflict_cnt increments on any conflict and saturates at 2^CNT_W-1 (no wrap).
- err_clr has priority over a same-cycle conflict: the count becomes 0, the err flag becomes 0, and that conflict is not counted. The conflict pulse itself still fires.
- Widths: no arithmetic on data; owner_idx is zero-extended to its declared width.

Decomposition:
- Shared package: source index constants (SRC_R0=0 .. SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21), the lock state enum, and the default WIDTH/NSRC.
- One sub-module, prio_enc: combinational NSRC-in one-hot/multi-hot to index + any + multi, with a HI_PRIO parameter.
- The mux, lock FSM and counters live in bus_mux_reg.

Test Plan:
- Reset then idle: clear_n low mid-cycle -> all outputs 0 immediately. No enables for 5 cycles -> bus_out stays 0, bus_valid=0.
- Single driver: src_out bit 20 (PC) with data 0x0000_1234 -> next cycle bus_out=0x1234, owner_idx=20, bus_valid=1, conflict=0. Enables then drop -> bus_out holds 0x1234, bus_valid=0.
- Multi driver, HI_PRIO=1: bits 3 (0xA) and 21 (0xB) set -> bus_out=0xB, owner_idx=21, conflict pulse 1 cycle, conflict_err=1, conflict_cnt=1.
  - Repeat with HI_PRIO=0 -> bus_out=0xA, owner_idx=3.
- Lock:
  - lock_req=1 with R5 (0x55) -> locked=1.
  - Next sample with R5=0x66 plus R7 -> bus_out=0x66, conflict=1.
  - lock_req=0 -> locked=0.
  - Then R7 alone (0x77) -> bus_out=0x77.
- Saturation/clear, CNT_W=2: drive 5 consecutive conflict cycles -> cnt=3. err_clr together with a conflict -> cnt=0, err=0, conflict pulse still 1.
- Reset mid-lock: locked=1, assert clear_n=0 -> locked=0, owner_idx=0, bus_out=0 without waiting for a clock edge.
